// File: rtl/output_serializer_pkg.sv
// Shared constants for the output serializer: FSM state encodings and line levels.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Config macro: OUT_PARITY_EN adds the PARITY state encoding.
package output_serializer_pkg;

   // The serial line rests high between frames.
   localparam logic TX_IDLE  = 1'b1;
   localparam logic TX_START = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef OUT_PARITY_EN
      , ST_PARITY = 3'd4
`endif
   } state_t;

endpackage

// File: rtl/output_serializer_fifo.sv
// out_fifo: word queue between the CPU write strobe and the serializer FSM.
// Latency: a pushed word is visible at o_data (head) one clock after the push edge.
// Backpressure: pushes while o_full is high and pops while o_empty is high are ignored.
// Ports: i_clk, i_reset (sync, active-high), i_push/i_data write side,
//        i_pop/o_data read side (o_data is the current head), o_full/o_empty registered flags.
module out_fifo #(
   parameter int Width     = 8,
   parameter int DepthLog2 = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [Width-1:0] i_data,
   output logic [Width-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam logic [DepthLog2:0] CountFull = (DepthLog2+1)'(1 << DepthLog2);

   logic [Width-1:0]     r_mem [1 << DepthLog2];
   logic [DepthLog2-1:0] r_wr_ptr;
   logic [DepthLog2-1:0] r_rd_ptr;
   logic [DepthLog2:0]   r_count;
   logic                 r_full;
   logic                 r_empty;
   logic                 w_push;
   logic                 w_pop;
   logic [DepthLog2:0]   w_count_nxt;

   assign w_push = i_push && !r_full;
   assign w_pop  = i_pop  && !r_empty;

   // Simultaneous push and pop leave the occupancy unchanged.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage needs no reset; occupancy tracking decides what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers are exactly DepthLog2 bits wide so they wrap modulo depth for free.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CountFull);
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/output_serializer.sv
// output_serializer: buffers CPU output words and sends each as an async serial frame
//    (start 0, DataWidth bits LSB first, optional even parity, stop 1), BaudDiv clocks per bit.
// Latency: Ld into an empty, idle serializer drives the start bit from the next clock edge.
// Backpressure: none toward the CPU; a write while Full is dropped and sets sticky Overrun.
// Ports: i_Clk, i_Reset (sync, active-high), i_Ld/i_DIn write strobe and word,
//        o_Tx serial line (registered, idle high), o_Busy, o_Full, o_Overrun.
// Config macro: OUT_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module output_serializer
   import output_serializer_pkg::*;
#(
   parameter int DataWidth     = 8,
   parameter int BaudDiv       = 16,
   parameter int FifoDepthLog2 = 2
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset,
   input  logic                 i_Ld,
   input  logic [DataWidth-1:0] i_DIn,
   output logic                 o_Tx,
   output logic                 o_Busy,
   output logic                 o_Full,
   output logic                 o_Overrun
);

   localparam int BaudW = (BaudDiv > 2) ? $clog2(BaudDiv) : 1;
   localparam int BitW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(BaudDiv - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

   state_t               r_state;
   logic                 r_tx;
   logic                 r_overrun;
   logic [BaudW-1:0]     r_baud;
   logic [BitW-1:0]      r_bit;
   logic [DataWidth-1:0] r_shift;
`ifdef OUT_PARITY_EN
   logic                 r_parity;
`endif

   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_bit_end;
   logic [DataWidth-1:0] w_fifo_dat;

   // Overrun is judged against the registered Full, so a pop at the same edge does not rescue the write.
   assign w_push    = i_Ld && !w_full;
   assign w_pop     = (r_state == ST_IDLE) && !w_empty;
   assign w_bit_end = (r_baud == BaudLast);

   out_fifo #(
      .Width     (DataWidth),
      .DepthLog2 (FifoDepthLog2)
   ) u_fifo (
      .i_clk   (i_Clk),
      .i_reset (i_Reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (i_DIn),
      .o_data  (w_fifo_dat),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // r_tx is loaded with the level of the period being entered, so the line changes
   // on the same edge as the state and no combinational path reaches o_Tx.
   // r_shift is pre-shifted: r_shift[0] is always the next data bit to send.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_state   <= ST_IDLE;
         r_tx      <= TX_IDLE;
         r_overrun <= 1'b0;
         r_baud    <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
`ifdef OUT_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         if (i_Ld && w_full) r_overrun <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               r_tx   <= TX_IDLE;
               r_baud <= '0;
               r_bit  <= '0;
               if (!w_empty) begin
                  r_shift  <= w_fifo_dat;
`ifdef OUT_PARITY_EN
                  r_parity <= ^w_fifo_dat;
`endif
                  r_tx     <= TX_START;
                  r_state  <= ST_START;
               end
            end

            ST_START: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_state <= ST_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

            ST_DATA: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit == BitLast) begin
                     r_bit   <= '0;
`ifdef OUT_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= ST_PARITY;
`else
                     r_tx    <= TX_IDLE;
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

`ifdef OUT_PARITY_EN
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= TX_IDLE;
                  r_state <= ST_STOP;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
`endif

            ST_STOP: begin
               r_tx <= TX_IDLE;
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

            default: begin
               r_tx    <= TX_IDLE;
               r_baud  <= '0;
               r_bit   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_Tx      = r_tx;
   assign o_Busy    = (r_state != ST_IDLE) || !w_empty;
   assign o_Full    = w_full;
   assign o_Overrun = r_overrun;

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer (DataWidth=8, BaudDiv=4, FifoDepthLog2=2): directed frames,
// overflow, reset abort and randomized traffic against a queue-based line model.
module tb_output_serializer;

   localparam int DW    = 8;
   localparam int B     = 4;
   localparam int DEPTH = 4;
`ifdef OUT_PARITY_EN
   localparam int NBITS = DW + 3;
`else
   localparam int NBITS = DW + 2;
`endif
   localparam int FRAME = NBITS * B;

   logic          clk = 1'b0;
   logic          i_Reset = 1'b1;
   logic          i_Ld = 1'b0;
   logic [DW-1:0] i_DIn = '0;
   logic          o_Tx, o_Busy, o_Full, o_Overrun;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   output_serializer #(
      .DataWidth     (DW),
      .BaudDiv       (B),
      .FifoDepthLog2 (2)
   ) dut (
      .i_Clk     (clk),
      .i_Reset   (i_Reset),
      .i_Ld      (i_Ld),
      .i_DIn     (i_DIn),
      .o_Tx      (o_Tx),
      .o_Busy    (o_Busy),
      .o_Full    (o_Full),
      .o_Overrun (o_Overrun)
   );

   // ---------------- reference model: pending words + position within current frame
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_cur;
   bit            m_active;
   int            m_pos;
   bit            m_full;
   bit            m_ovr;

   logic tx_hist[$];
   logic busy_hist[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic void model_edge(input logic ld, input logic [DW-1:0] din, input logic rst);
      bit full_before;
      if (rst) begin
         m_q.delete();
         m_active = 0;
         m_pos    = 0;
         m_full   = 0;
         m_ovr    = 0;
         return;
      end
      full_before = m_full;
      if (ld && full_before) m_ovr = 1;
      if (m_active) begin
         m_pos++;
         if (m_pos == FRAME) m_active = 0;
      end else if (m_q.size() > 0) begin
         m_cur    = m_q.pop_front();
         m_active = 1;
         m_pos    = 0;
      end
      if (ld && !full_before) m_q.push_back(din);
      m_full = (m_q.size() == DEPTH);
   endfunction

   // Line level for the current position: start, data LSB first, [parity], stop.
   function automatic logic model_tx();
      int idx;
      if (!m_active) return 1'b1;
      idx = m_pos / B;
      if (idx == 0) return 1'b0;
      if (idx <= DW) return m_cur[idx-1];
`ifdef OUT_PARITY_EN
      if (idx == DW + 1) return ^m_cur;
`endif
      return 1'b1;
   endfunction

   function automatic logic model_busy();
      return m_active || (m_q.size() > 0);
   endfunction

   task automatic step(input logic ld, input logic [DW-1:0] din, input logic rst);
      i_Ld    = ld;
      i_DIn   = din;
      i_Reset = rst;
      @(posedge clk);
      model_edge(ld, din, rst);
      @(negedge clk);
      tx_hist.push_back(o_Tx);
      busy_hist.push_back(o_Busy);
      chk("tx", o_Tx, model_tx());
      chk("busy", o_Busy, model_busy());
      chk("full", o_Full, m_full);
      chk("overrun", o_Overrun, m_ovr);
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((o_Busy || model_busy()) && n < max_cyc) begin
         step(1'b0, '0, 1'b0);
         n++;
      end
      // a couple of idle cycles so the last stop bit is fully in the history
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      if (n >= max_cyc) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   // Index of the first high-to-low transition at or after 'from', or -1.
   function automatic int find_start(input int from);
      int lo = (from < 1) ? 1 : from;
      for (int i = lo; i < tx_hist.size(); i++)
         if (tx_hist[i-1] == 1'b1 && tx_hist[i] == 1'b0) return i;
      return -1;
   endfunction

   // Receiver: sample mid-bit from the recorded line; start and stop levels must be right.
   function automatic logic [DW-1:0] decode(input int s);
      logic [DW-1:0] w;
      if (s < 0 || s + FRAME > tx_hist.size()) return 'x;
      if (tx_hist[s + B/2] !== 1'b0) return 'x;
      if (tx_hist[s + (NBITS-1)*B + B/2] !== 1'b1) return 'x;
      for (int k = 0; k < DW; k++) w[k] = tx_hist[s + (k+1)*B + B/2];
      return w;
   endfunction

   initial begin
      int base, s, s2, bf;
      logic [DW-1:0] d;

      // ---- reset
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      chk("rst_tx", o_Tx, 1);
      chk("rst_busy", o_Busy, 0);
      chk("rst_full", o_Full, 0);
      chk("rst_overrun", o_Overrun, 0);

      // ---- single word 0xA5: start on the edge after the write, busy drops 40 clocks later
      base = tx_hist.size();
      step(1'b1, 8'hA5, 1'b0);
      chk("a5_tx_at_load", o_Tx, 1);
      step(1'b0, '0, 1'b0);
      chk("a5_tx_next", o_Tx, 0);
      drain(200);
      s = find_start(base);
      chk("a5_start_idx", s - base, 1);
      chk("a5_word", decode(s), 8'hA5);
      bf = -1;
      for (int i = s; i < busy_hist.size(); i++)
         if (busy_hist[i] == 1'b0 && bf < 0) bf = i;
      chk("a5_busy_fall", bf - s, FRAME);

      // ---- six back-to-back writes: fifth fills, sixth dropped
      base = tx_hist.size();
      for (int k = 1; k <= 6; k++) begin
         step(1'b1, 8'(k), 1'b0);
         if (k == 4) chk("ovf_full_after4", o_Full, 0);
         if (k == 5) begin
            chk("ovf_full_after5", o_Full, 1);
            chk("ovf_ovr_after5", o_Overrun, 0);
         end
      end
      chk("ovf_ovr_after6", o_Overrun, 1);
      drain(600);
      chk("ovf_ovr_sticky", o_Overrun, 1);
      s = find_start(base);
      for (int k = 1; k <= 5; k++) begin
         chk("ovf_frame", decode(s), k);
         s = find_start(s + FRAME);
      end
      chk("ovf_no_sixth", s, -1);

      // ---- reset clears overrun, then 0x00 / 0xFF spacing
      step(1'b0, '0, 1'b1);
      chk("rst2_overrun", o_Overrun, 0);
      base = tx_hist.size();
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'hFF, 1'b0);
      drain(300);
      s  = find_start(base);
      s2 = find_start(s + FRAME);
      chk("gap_first", decode(s), 8'h00);
      chk("gap_second", decode(s2), 8'hFF);
      chk("gap_spacing", s2 - s, FRAME + 1);

      // ---- reset during the third data bit aborts the frame
      step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'h99, 1'b0);
      for (int i = 0; i < B + 2*B + 1; i++) step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      chk("abort_tx", o_Tx, 1);
      chk("abort_busy", o_Busy, 0);
      base = tx_hist.size();
      step(1'b1, 8'h3C, 1'b0);
      drain(200);
      s = find_start(base);
      chk("abort_3c", decode(s), 8'h3C);
      chk("abort_only_one", find_start(s + FRAME), -1);

      // ---- randomized traffic: sparse then dense writes, rare resets
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            step(1'b0, '0, 1'b1);
         end else begin
            d = 8'($urandom);
            if (i < 1000) step(($urandom_range(0, 39) == 0), d, 1'b0);
            else          step(($urandom_range(0, 5) == 0), d, 1'b0);
         end
      end
      drain(1000);
      chk("end_idle_tx", o_Tx, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 Parameter DataWidth, default 8: width of each output word; matches the CPU data path.
REQ-002 Parameter BaudDiv, default 16: clocks per serial bit; legal range >= 2.
REQ-003 Parameter FifoDepthLog2, default 2: FIFO holds 2^FifoDepthLog2 words.
REQ-004 Clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Ld  in  1  write strobe; the CPU output-load strobe drives it.
REQ-007 DIn  in  DataWidth  word to serialize; the CPU output-register data drives it.
REQ-008 Tx  out  1  registered serial line; idle high.
REQ-009 Busy  out  1  high while the FIFO is non-empty or a frame is in flight.
REQ-010 Full  out  1  FIFO count equals depth; registered.
REQ-011 Overrun  out  1  sticky flag; a write was dropped.

Function
REQ-012 Ld high with Full low SHALL push DIn into the FIFO at that edge.
REQ-013 Ld high with Full high SHALL drop DIn and set Overrun, even if a pop occurs at the same edge.
REQ-014 A push and a pop at the same edge SHALL leave the count unchanged; FIFO pointers wrap modulo depth.
REQ-015 FSM states: IDLE, START, DATA, PARITY (only when macro set), STOP.
REQ-016 IDLE with FIFO non-empty SHALL pop the head into the shift register and enter START at the same edge.
REQ-017 START SHALL drive Tx=0 for BaudDiv clocks.
REQ-018 DATA SHALL shift out DataWidth bits, LSB first, each held for BaudDiv clocks; a bit counter tracks position.
REQ-019 STOP SHALL drive Tx=1 for BaudDiv clocks, then return to IDLE.
REQ-020 Latency: Ld at edge n into an empty FIFO with IDLE state SHALL give Tx low from edge n+1 onward.
REQ-021 Back-to-back frames SHALL be separated by exactly one IDLE clock; frame period (DataWidth+2)*BaudDiv+1 clocks without parity.
REQ-022 Busy SHALL be low only when state is IDLE and the FIFO is empty.

Reset
REQ-023 Reset SHALL force Tx=1, Busy=0, Full=0, Overrun=0, FIFO empty, state IDLE, and counters to 0 at the next edge.
REQ-024 Reset mid-frame SHALL abort the frame with no partial stop bit; queued words are discarded.
REQ-025 Overrun SHALL clear only on Reset.

Configuration
REQ-026 Macro OUT_PARITY_EN defined: PARITY state inserted between DATA and STOP, driving the even-parity bit (XOR of data bits) for BaudDiv clocks; frame lengthens by BaudDiv.
REQ-027 Macro OUT_PARITY_EN undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Structure
REQ-028 FSM state encodings SHALL live in the shared constants include used by the sequence control.
REQ-029 The FIFO SHALL be a sub-module named out_fifo, with push, pop, data, full, and empty ports.
REQ-030 Baud counter, bit counter, shift register, and FSM SHALL reside in output_serializer.

Verification (DataWidth=8, BaudDiv=4, FifoDepthLog2=2)
REQ-031 Single write 0xA5 -> Tx: 0 x4, then 1,0,1,0,0,1,0,1 (4 clocks each), then 1 x4; Busy falls 40 clocks after Tx first goes low.
REQ-032 Six consecutive Ld cycles with 0x01..0x06 -> 0x06 dropped, Overrun=1, Full high after the fifth write; frames 0x01..0x05 sent in order.
REQ-033 Writes 0x00 then 0xFF -> second start bit begins 41 clocks after the first.
REQ-034 Reset asserted in the third DATA bit -> next edge gives Tx=1, Busy=0; a later write of 0x3C is sent correctly.
REQ-035 With OUT_PARITY_EN, write 0x07 -> parity bit 1 after bit 7; frame is 44 clocks.
